// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   if_state_e : fetch FSM states (IDLE, FETCH, HOLD, DRAIN)
//   pc_sel_e   : next-PC mux select used by fetch_pc_reg
//   NOP_WORD and MIPS opcode constants used by fetch/decode neighbours
//   word_align : clears the two byte-offset bits of an address
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_HOLD  = 2'd2,
    IF_DRAIN = 2'd3
  } if_state_e;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_BRANCH = 2'd2
  } pc_sel_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [5:0]  OP_RTYPE = 6'h00;
  localparam logic [5:0]  OP_LW    = 6'h23;
  localparam logic [5:0]  OP_SW    = 6'h2B;
  localparam logic [5:0]  OP_BEQ   = 6'h04;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_reg.sv
// fetch_pc_reg: program counter register and its next-PC mux.
//   clk, rst_n    : clock, async active-low reset (loads RESET_PC)
//   pc_sel        : PC_HOLD keeps the PC, PC_INC loads inc_base+4,
//                   PC_BRANCH loads branch_target with bits [1:0] cleared
//   inc_base      : address the +4 increment is taken from
//   branch_target : redirect address
//   pc_q          : current PC
//   pc_d          : PC value for the next cycle (lets the caller latch it early)
module fetch_pc_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pc_sel_e     pc_sel,
  input  logic [31:0] inc_base,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_q,
  output logic [31:0] pc_d
);

  always_comb begin
    pc_d = pc_q;
    case (pc_sel)
      PC_INC:    pc_d = inc_base + 32'd4;  // wraps modulo 2^32
      PC_BRANCH: pc_d = word_align(branch_target);
      default:   pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= word_align(RESET_PC);
    else        pc_q <= pc_d;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch stage feeding the decoder.
//   clk, rst_n                 : clock, async active-low reset
//   imem_req/imem_addr         : word read request, held until imem_ack
//   imem_ack/imem_rdata        : read response (may arrive same cycle as req)
//   if_valid/if_instr/if_pc/if_pc_plus4 : held instruction to decode
//   id_ready                   : decoder takes the held instruction
//   branch_taken/branch_target : redirect; flushes held instruction and
//                                discards an in-flight fetch
//   fetch_count                : instructions handed to decode (wraps)
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_pc_plus4,
  input  logic             id_ready,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [CNT_W-1:0] fetch_count
);

  if_state_e        state_q, state_d;
  pc_sel_e          pc_sel;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic             if_valid_q, if_valid_d;
  logic [31:0]      if_instr_q, if_instr_d;
  logic [31:0]      if_pc_q, if_pc_d;
  logic [31:0]      if_pc_plus4_q, if_pc_plus4_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_sel        (pc_sel),
    .inc_base      (req_addr_q),
    .branch_target (branch_target),
    .pc_q          (pc_q),
    .pc_d          (pc_d)
  );

  always_comb begin
    state_d       = state_q;
    pc_sel        = PC_HOLD;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      IF_IDLE: state_d = IF_FETCH;
      IF_FETCH: begin
        if (branch_taken) begin
          pc_sel  = PC_BRANCH;
          // Without an ack the old request must stay up until it completes.
          state_d = imem_ack ? IF_FETCH : IF_DRAIN;
        end else if (imem_ack) begin
          pc_sel        = PC_INC;
          if_valid_d    = 1'b1;
          if_instr_d    = imem_rdata;
          if_pc_d       = req_addr_q;
          if_pc_plus4_d = req_addr_q + 32'd4;
          state_d       = IF_HOLD;
        end
      end
      IF_HOLD: begin
        if (branch_taken) begin
          pc_sel     = PC_BRANCH;
          if_valid_d = 1'b0;
          state_d    = IF_FETCH;
        end else if (id_ready) begin
          if_valid_d    = 1'b0;
          fetch_count_d = fetch_count_q + CNT_W'(1);
          state_d       = IF_FETCH;
        end
      end
      IF_DRAIN: begin
        if (branch_taken) pc_sel = PC_BRANCH;
        if (imem_ack)     state_d = IF_FETCH;
      end
      default: state_d = IF_IDLE;
    endcase
    // The request address is latched whenever FETCH is (re)entered, so it
    // stays stable for the whole request even if the PC moves in DRAIN.
    req_addr_d = (state_d == IF_FETCH) ? pc_d : req_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IF_IDLE;
      req_addr_q    <= word_align(RESET_PC);
      if_valid_q    <= 1'b0;
      if_instr_q    <= NOP_WORD;
      if_pc_q       <= 32'h0;
      if_pc_plus4_q <= 32'h0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_req    = (state_q == IF_FETCH) || (state_q == IF_DRAIN);
  assign imem_addr   = req_addr_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc_plus4_q;
  assign fetch_count = fetch_count_q;

endmodule
